// File: rtl/sw_rxbuf_len_pkg.sv
// Shared types and helpers for the SW RX buffer length manager.
//   state_t  : descriptor FSM states
//   ALIGN    : byte alignment of a 64-bit buffer word
//   LEN_W    : width of every byte-length field on the interface
//   roundup(): round a byte count up to a multiple of the word size
package sw_rxbuf_len_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, REL} state_t;

  localparam int unsigned ALIGN = 8;
  localparam int unsigned LEN_W = 16;

  // align must be a power of two; the result carries one extra bit so that
  // a 16-bit length near 64K cannot wrap when rounded up.
  function automatic logic [LEN_W:0] roundup(input logic [LEN_W-1:0] len,
                                             input int unsigned align);
    logic [LEN_W:0] mask;
    mask = (LEN_W+1)'(align - 1);
    return ({1'b0, len} + mask) & ~mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req  : per-requester request vector
//   last : index of the most recent grant; search starts at last+1
//   gnt  : one-hot grant
//   idx  : index of the granted requester
//   any  : at least one request present
// N must be a power of two so that the index arithmetic wraps on its own.
module rr_arbiter #(
  parameter int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int off = 1; off <= N; off++) begin
      cand = last + IW'(off);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/sw_rxbuf_len_mgr.sv
// Per-flow length manager behind the SW RX buffer.
// Accumulates announced packet bytes per flow, keeps a per-flow read pointer,
// issues one DMA read descriptor at a time (round-robin over flows) and hands
// the consumed space back to the buffer once the DMA reports completion.
// Ports:
//   CLK, RESET            clock, synchronous active-low reset
//   RX_NEWLEN[_DV/_RDY]   per-flow new packet length in bytes (16 bits per flow)
//   RX_RELLEN[_DV]        per-flow released length, one-cycle strobe
//   DMA_REQ/FLOW/ADDR/LEN descriptor, held stable until DMA_ACK
//   DMA_ACK, DMA_DONE     descriptor accepted / transfer finished
//   ERR                   sticky pending-counter overflow
module sw_rxbuf_len_mgr import sw_rxbuf_len_pkg::*; #(
  parameter int DATA_WIDTH      = 8 * ALIGN,
  parameter int FLOWS           = 2,
  parameter int TOTAL_FLOW_SIZE = 16384,
  parameter int MAX_XFER        = 512,
  localparam int FW = (FLOWS > 1) ? $clog2(FLOWS) : 1,
  localparam int AW = $clog2(FLOWS * TOTAL_FLOW_SIZE)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [LEN_W*FLOWS-1:0] RX_NEWLEN,
  input  logic [FLOWS-1:0]       RX_NEWLEN_DV,
  output logic [FLOWS-1:0]       RX_NEWLEN_RDY,
  output logic [LEN_W*FLOWS-1:0] RX_RELLEN,
  output logic [FLOWS-1:0]       RX_RELLEN_DV,
  output logic                   DMA_REQ,
  output logic [FW-1:0]          DMA_FLOW,
  output logic [AW-1:0]          DMA_ADDR,
  output logic [LEN_W-1:0]       DMA_LEN,
  input  logic                   DMA_ACK,
  input  logic                   DMA_DONE,
  output logic                   ERR
);

  localparam int ALIGN_B = DATA_WIDTH / 8;
  localparam int PTR_W   = $clog2(TOTAL_FLOW_SIZE);
  localparam int PW      = PTR_W + 1;
  localparam int SW      = LEN_W + 2;

  state_t          state_q, state_d;
  logic [FW-1:0]   lg_q, lg_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;
  logic [FW-1:0]   flow_q, flow_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [PW-1:0]    pend [FLOWS];
  logic [PTR_W-1:0] rdp  [FLOWS];
  logic [FLOWS-1:0] ovf;
  logic [FLOWS-1:0] busy;
  logic [FLOWS-1:0] acc;

  logic [FLOWS-1:0] gnt;
  logic [FW-1:0]    gidx;
  logic             gany;

  assign acc = RX_NEWLEN_DV & RX_NEWLEN_RDY;

  for (genvar g = 0; g < FLOWS; g++) begin : g_flow
    logic [PW-1:0]    pend_q, pend_d;
    logic [PTR_W-1:0] rdp_q, rdp_d;
    logic [SW-1:0]    add, sub, net;
    logic             rel_here, ovf_l;

    // Add and release may hit the same flow in one cycle; apply them as one
    // net update. sub never exceeds pend_q, so net cannot underflow.
    always_comb begin
      rel_here = (state_q == REL) && (flow_q == FW'(g));
      add      = acc[g] ? SW'(roundup(RX_NEWLEN[LEN_W*g +: LEN_W], ALIGN_B)) : '0;
      sub      = rel_here ? SW'(len_q) : '0;
      net      = SW'(pend_q) + add - sub;
      ovf_l    = net > SW'(TOTAL_FLOW_SIZE);
      pend_d   = ovf_l ? PW'(TOTAL_FLOW_SIZE) : net[PW-1:0];
      // Truncation to PTR_W bits is the modulo-TFS wrap.
      rdp_d    = rel_here ? rdp_q + len_q[PTR_W-1:0] : rdp_q;
    end

    always_ff @(posedge CLK) begin
      if (!RESET) begin
        pend_q <= '0;
        rdp_q  <= '0;
      end else begin
        pend_q <= pend_d;
        rdp_q  <= rdp_d;
      end
    end

    assign pend[g] = pend_q;
    assign rdp[g]  = rdp_q;
    assign ovf[g]  = ovf_l;
    assign busy[g] = (pend_q != '0);
  end

  rr_arbiter #(.N(FLOWS)) u_arb (
    .req  (busy),
    .last (lg_q),
    .gnt  (gnt),
    .idx  (gidx),
    .any  (gany)
  );

  logic [PW-1:0]    sel_pend;
  logic [PTR_W-1:0] sel_rdp;
  logic [PW-1:0]    room;
  logic [SW-1:0]    lim;

  // Descriptor length: bounded by what is pending, by MAX_XFER and by the
  // distance to the end of the flow region so one descriptor never wraps.
  always_comb begin
    sel_pend = '0;
    sel_rdp  = '0;
    for (int i = 0; i < FLOWS; i++) begin
      if (gnt[i]) begin
        sel_pend = sel_pend | pend[i];
        sel_rdp  = sel_rdp | rdp[i];
      end
    end
    room = PW'(TOTAL_FLOW_SIZE) - {1'b0, sel_rdp};
    lim  = SW'(MAX_XFER);
    if (SW'(sel_pend) < lim) lim = SW'(sel_pend);
    if (SW'(room) < lim)     lim = SW'(room);
  end

  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    flow_d  = flow_q;
    addr_d  = addr_q;
    len_d   = len_q;
    rdy_d   = 1'b1;
    err_d   = err_q | (|ovf);
    case (state_q)
      IDLE: begin
        if (gany) begin
          flow_d  = gidx;
          addr_d  = (AW'(gidx) << PTR_W) | AW'(sel_rdp);
          len_d   = LEN_W'(lim);
          state_d = REQ;
        end
      end
      REQ:  if (DMA_ACK)  state_d = WAIT;
      WAIT: if (DMA_DONE) state_d = REL;
      REL: begin
        lg_d    = flow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      lg_q    <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  // Descriptor payload is only consumed while the FSM says it is valid.
  always_ff @(posedge CLK) begin
    flow_q <= flow_d;
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  always_comb begin
    RX_RELLEN    = '0;
    RX_RELLEN_DV = '0;
    if (state_q == REL) begin
      for (int i = 0; i < FLOWS; i++) begin
        if (flow_q == FW'(i)) begin
          RX_RELLEN_DV[i]               = 1'b1;
          RX_RELLEN[LEN_W*i +: LEN_W]   = len_q;
        end
      end
    end
  end

  assign RX_NEWLEN_RDY = {FLOWS{rdy_q}};
  assign DMA_REQ       = (state_q == REQ);
  assign DMA_FLOW      = flow_q;
  assign DMA_ADDR      = addr_q;
  assign DMA_LEN       = len_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_sw_rxbuf_len_mgr.sv
module tb_sw_rxbuf_len_mgr;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] RX_NEWLEN;
  logic [1:0]  RX_NEWLEN_DV;
  logic [1:0]  RX_NEWLEN_RDY;
  logic [31:0] RX_RELLEN;
  logic [1:0]  RX_RELLEN_DV;
  logic        DMA_REQ;
  logic [0:0]  DMA_FLOW;
  logic [14:0] DMA_ADDR;
  logic [15:0] DMA_LEN;
  logic        DMA_ACK;
  logic        DMA_DONE;
  logic        ERR;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  sw_rxbuf_len_mgr dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .RX_NEWLEN     (RX_NEWLEN),
    .RX_NEWLEN_DV  (RX_NEWLEN_DV),
    .RX_NEWLEN_RDY (RX_NEWLEN_RDY),
    .RX_RELLEN     (RX_RELLEN),
    .RX_RELLEN_DV  (RX_RELLEN_DV),
    .DMA_REQ       (DMA_REQ),
    .DMA_FLOW      (DMA_FLOW),
    .DMA_ADDR      (DMA_ADDR),
    .DMA_LEN       (DMA_LEN),
    .DMA_ACK       (DMA_ACK),
    .DMA_DONE      (DMA_DONE),
    .ERR           (ERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (DMA_REQ) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic newlen(input int f, input int len);
    RX_NEWLEN[16*f +: 16] = 16'(len);
    RX_NEWLEN_DV[f]       = 1'b1;
    tick();
    RX_NEWLEN_DV = '0;
  endtask

  // One full descriptor: request, stall with a stray DONE, ACK, one WAIT
  // cycle, DONE, then the release cycle (optionally with a NEWLEN injected).
  task automatic xfer(input bit chk, input int ef, input int ea, input int el,
                      input bit inj, input int inf, input int inl, output int got);
    bit ok;
    logic [15:0] rel;
    got = 0;
    wait_req(20, ok);
    check("req_seen", 32'(ok), 1);
    if (!ok) return;
    if (chk) begin
      check("dma_flow", 32'(DMA_FLOW), ef);
      check("dma_addr", 32'(DMA_ADDR), ea);
      check("dma_len",  32'(DMA_LEN),  el);
    end
    DMA_DONE = 1'b1;
    tick();
    DMA_DONE = 1'b0;
    check("req_hold", 32'(DMA_REQ), 1);
    if (chk) check("addr_hold", 32'(DMA_ADDR), ea);
    DMA_ACK = 1'b1;
    tick();
    DMA_ACK = 1'b0;
    check("req_drop", 32'(DMA_REQ), 0);
    tick();
    check("rel_early", 32'(RX_RELLEN_DV), 0);
    DMA_DONE = 1'b1;
    tick();
    DMA_DONE = 1'b0;
    check("rel_dv", 32'(RX_RELLEN_DV), 32'(1) << ef);
    rel = RX_RELLEN[16*ef +: 16];
    if (chk) check("rellen", 32'(rel), el);
    check("rellen_other", RX_RELLEN & ~(32'h0000_FFFF << (16*ef)), 0);
    got = int'(rel);
    if (inj) begin
      RX_NEWLEN[16*inf +: 16] = 16'(inl);
      RX_NEWLEN_DV[inf]       = 1'b1;
    end
    tick();
    RX_NEWLEN_DV = '0;
    check("rel_pulse", 32'(RX_RELLEN_DV), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  l;
    int  tot;
    bit  ok;
    RX_NEWLEN    = '0;
    RX_NEWLEN_DV = '0;
    DMA_ACK      = 1'b0;
    DMA_DONE     = 1'b0;
    RESET        = 1'b0;

    // Reset with flow0 NEWLEN=60 held valid throughout.
    RX_NEWLEN[15:0] = 16'd60;
    RX_NEWLEN_DV    = 2'b01;
    repeat (3) tick();
    check("rst_rdy",    32'(RX_NEWLEN_RDY), 0);
    check("rst_req",    32'(DMA_REQ), 0);
    check("rst_reldv",  32'(RX_RELLEN_DV), 0);
    check("rst_rellen", RX_RELLEN, 0);
    check("rst_err",    32'(ERR), 0);
    RESET = 1'b1;
    tick();
    check("rdy_post_rst", 32'(RX_NEWLEN_RDY), 3);
    tick();
    RX_NEWLEN_DV = '0;
    check("lat_t1", 32'(DMA_REQ), 0);
    tick();
    check("lat_t2", 32'(DMA_REQ), 1);
    xfer(1, 0, 0, 64, 0, 0, 0, l);
    wait_req(6, ok);
    check("t2_idle", 32'(ok), 0);

    // Flow1 1500 bytes -> 1504 split at MAX_XFER.
    newlen(1, 1500);
    tot = 0;
    xfer(1, 1, 16384, 512, 0, 0, 0, l); tot += l;
    xfer(1, 1, 16896, 512, 0, 0, 0, l); tot += l;
    xfer(1, 1, 17408, 480, 0, 0, 0, l); tot += l;
    check("t3_sum", tot, 1504);
    wait_req(6, ok);
    check("t3_idle", 32'(ok), 0);

    // Walk flow0 rd_ptr from 64 to 16256, then a wrap-splitting 512.
    newlen(0, 16192);
    for (int k = 0; k < 31; k++) xfer(1, 0, 64 + 512*k, 512, 0, 0, 0, l);
    xfer(1, 0, 15936, 320, 0, 0, 0, l);
    newlen(0, 512);
    xfer(1, 0, 16256, 128, 0, 0, 0, l);
    xfer(1, 0, 0, 384, 0, 0, 0, l);

    // Both flows pending, last grant flow0; NEWLEN=100 on flow1 during its release.
    RX_NEWLEN    = {16'd1024, 16'd512};
    RX_NEWLEN_DV = 2'b11;
    tick();
    RX_NEWLEN_DV = '0;
    xfer(1, 1, 17888, 512, 1, 1, 100, l);
    xfer(1, 0, 384,   512, 0, 0, 0,   l);
    xfer(1, 1, 18400, 512, 0, 0, 0,   l);
    xfer(1, 1, 18912, 104, 0, 0, 0,   l);
    wait_req(6, ok);
    check("t5_idle", 32'(ok), 0);

    // Overflow: 16384 + 8 on flow0 saturates at 16384.
    newlen(0, 16384);
    check("err_pre", 32'(ERR), 0);
    newlen(0, 8);
    check("err_set", 32'(ERR), 1);
    tot = 0;
    for (int k = 0; k < 40 && tot < 16384; k++) begin
      xfer(0, 0, 0, 0, 0, 0, 0, l);
      if (l == 0) break;
      tot += l;
    end
    check("drain_total", tot, 16384);
    check("err_sticky", 32'(ERR), 1);
    wait_req(8, ok);
    check("drain_idle", 32'(ok), 0);

    // Reset while a descriptor is in WAIT.
    newlen(1, 64);
    wait_req(20, ok);
    check("w_req", 32'(ok), 1);
    DMA_ACK = 1'b1;
    tick();
    DMA_ACK = 1'b0;
    check("w_in_wait", 32'(DMA_REQ), 0);
    RESET = 1'b0;
    tick();
    check("w_rst_err",   32'(ERR), 0);
    check("w_rst_reldv", 32'(RX_RELLEN_DV), 0);
    check("w_rst_rdy",   32'(RX_NEWLEN_RDY), 0);
    RESET    = 1'b1;
    DMA_DONE = 1'b1;
    tick();
    DMA_DONE = 1'b0;
    check("w_done_ign", 32'(RX_RELLEN_DV), 0);
    tick();
    check("w_no_rel", 32'(RX_RELLEN_DV), 0);
    wait_req(8, ok);
    check("w_idle", 32'(ok), 0);
    newlen(1, 8);
    xfer(1, 1, 16384, 8, 0, 0, 0, l);
    check("w_err_clear", 32'(ERR), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
